// File: rtl/nios2_oci_dct_pkg.sv
// rtl/nios2_oci_dct_pkg.sv - shared widths and record codes for the OCI DCT packer
package nios2_oci_dct_pkg;

   localparam int DCT_W   = 30;
   localparam int REC_W   = 2;
   localparam int MAX_REC = DCT_W / REC_W;
   localparam int CNT_W   = 4;

   typedef enum logic [REC_W-1:0] {
      DCT_ILL = 2'b00,
      DCT_NT  = 2'b01,
      DCT_TK  = 2'b10,
      DCT_UNC = 2'b11
   } dct_code_e;

endpackage

// File: rtl/nios2_oci_dct_out_reg.sv
// rtl/nios2_oci_dct_out_reg.sv - single-entry valid/ready holding register for packed DCT words
module nios2_oci_dct_out_reg
   import nios2_oci_dct_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [DCT_W-1:0] load_buffer,
   input  logic [CNT_W-1:0] load_count,
   output logic             free,
   output logic             valid,
   input  logic             ready,
   output logic [DCT_W-1:0] buffer,
   output logic [CNT_W-1:0] count
);

   // The slot can take a new word when empty or when its current word leaves this cycle.
   assign free = !valid || ready;

   // Hold the word until handshake; a load while draining replaces it without a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid  <= 1'b0;
         buffer <= '0;
         count  <= '0;
      end else if (load && free) begin
         valid  <= 1'b1;
         buffer <= load_buffer;
         count  <= load_count;
      end else if (ready) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/aula_20190912_qsys_nios2_qsys_0_oci_dct_packer.sv
// rtl/aula_20190912_qsys_nios2_qsys_0_oci_dct_packer.sv - packs 2-bit DCT records into 30-bit trace words (option: DCT_OVERFLOW_TRACK_EN)
module aula_20190912_qsys_nios2_qsys_0_oci_dct_packer
   import nios2_oci_dct_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             trc_on,
   input  logic             rec_valid,
   input  logic [REC_W-1:0] rec_code,
   input  logic             flush,
   output logic             dct_valid,
   input  logic             dct_ready,
   output logic [DCT_W-1:0] dct_buffer,
   output logic [CNT_W-1:0] dct_count,
   output logic             overflow,
   input  logic             clr_overflow
);

   logic [DCT_W-1:0] acc;
   logic [CNT_W-1:0] acc_cnt;
   logic             flush_pend;
   logic             trc_on_q;

   logic [DCT_W-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             pend_nxt;
   logic             rec_ok;
   logic             flush_req;
   logic             acc_full;
   logic             out_free;
   logic             xfer;
   logic             drop;

   assign rec_ok    = trc_on && rec_valid && (rec_code != DCT_ILL);
   // Trace stopping closes the current word just like an explicit flush.
   assign flush_req = flush || (trc_on_q && !trc_on);
   assign acc_full  = (acc_cnt == CNT_W'(MAX_REC));
   // Transfers work from registered accumulator state, so a word appears one edge after its trigger.
   assign xfer      = out_free && (acc_cnt != '0) && (acc_full || flush_pend);
   // A full accumulator that cannot hand off loses the new record; the CPU is never stalled.
   assign drop      = rec_ok && acc_full && !xfer;

   // Next accumulator: clear on transfer, then shift in the incoming record if it is kept.
   always_comb begin
      acc_nxt  = xfer ? '0 : acc;
      cnt_nxt  = xfer ? '0 : acc_cnt;
      if (rec_ok && !drop) begin
         acc_nxt = {acc_nxt[DCT_W-REC_W-1:0], rec_code};
         cnt_nxt = cnt_nxt + 1'b1;
      end
      pend_nxt = (xfer ? 1'b0 : flush_pend) || (flush_req && (cnt_nxt != '0));
   end

   // Accumulator, pending-flush and trace-enable history registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc        <= '0;
         acc_cnt    <= '0;
         flush_pend <= 1'b0;
         trc_on_q   <= 1'b0;
      end else begin
         acc        <= acc_nxt;
         acc_cnt    <= cnt_nxt;
         flush_pend <= pend_nxt;
         trc_on_q   <= trc_on;
      end
   end

   nios2_oci_dct_out_reg u_out_reg (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (xfer),
      .load_buffer (acc),
      .load_count  (acc_cnt),
      .free        (out_free),
      .valid       (dct_valid),
      .ready       (dct_ready),
      .buffer      (dct_buffer),
      .count       (dct_count)
   );

`ifdef DCT_OVERFLOW_TRACK_EN
   // Sticky drop flag; a drop in the clearing cycle wins so no loss goes unreported.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end
`else
   logic unused_ovf;
   assign unused_ovf = clr_overflow | drop;
   assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_aula_20190912_qsys_nios2_qsys_0_oci_dct_packer.sv
// tb/tb_aula_20190912_qsys_nios2_qsys_0_oci_dct_packer.sv - self-checking bench for the OCI DCT packer
module tb_aula_20190912_qsys_nios2_qsys_0_oci_dct_packer;
   import nios2_oci_dct_pkg::*;

`ifdef DCT_OVERFLOW_TRACK_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   logic             trc_on;
   logic             rec_valid;
   logic [REC_W-1:0] rec_code;
   logic             flush;
   logic             dct_valid;
   logic             dct_ready;
   logic [DCT_W-1:0] dct_buffer;
   logic [CNT_W-1:0] dct_count;
   logic             overflow;
   logic             clr_overflow;

   aula_20190912_qsys_nios2_qsys_0_oci_dct_packer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .trc_on       (trc_on),
      .rec_valid    (rec_valid),
      .rec_code     (rec_code),
      .flush        (flush),
      .dct_valid    (dct_valid),
      .dct_ready    (dct_ready),
      .dct_buffer   (dct_buffer),
      .dct_count    (dct_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DCT_W-1:0] buffer;
      logic [CNT_W-1:0] count;
   } exp_t;

   typedef struct {
      int               n;
      logic [REC_W-1:0] code;
      logic [DCT_W-1:0] buffer;
      logic [CNT_W-1:0] count;
   } vec_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, req);
      end
   endtask

   // Scoreboard monitor: pops on every handshake and checks that held words stay put.
   logic             prev_hold = 1'b0;
   logic [DCT_W-1:0] prev_buf;
   logic [CNT_W-1:0] prev_cnt;
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", 32'(dct_valid), 32'd1);
            chk("hold_buffer", 32'(dct_buffer), 32'(prev_buf));
            chk("hold_count", 32'(dct_count), 32'(prev_cnt));
         end
         if (dct_valid && dct_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word actual %h/%0d required none", dct_buffer, dct_count);
            end else begin
               e = q.pop_front();
               chk("sb_buffer", 32'(dct_buffer), 32'(e.buffer));
               chk("sb_count", 32'(dct_count), 32'(e.count));
            end
         end
         prev_hold = dct_valid && !dct_ready;
         prev_buf  = dct_buffer;
         prev_cnt  = dct_count;
      end
   end

   task automatic rec(input logic [REC_W-1:0] c);
      rec_valid = 1'b1;
      rec_code  = c;
      @(posedge clk);
      #1;
      rec_valid = 1'b0;
      rec_code  = 2'b00;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (q.size() != 0 && k < 40) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual %0d pending required 0", name, q.size());
         q.delete();
      end
      idle(2);
   endtask

   vec_t vt[6];

   initial begin
      vt[0] = '{15, 2'b10, 30'h2AAAAAAA, 4'd15};
      vt[1] = '{1,  2'b01, 30'h00000001, 4'd1};
      vt[2] = '{5,  2'b10, 30'h000002AA, 4'd5};
      vt[3] = '{8,  2'b11, 30'h0000FFFF, 4'd8};
      vt[4] = '{15, 2'b01, 30'h15555555, 4'd15};
      vt[5] = '{14, 2'b11, 30'h0FFFFFFF, 4'd14};

      reset_n      = 1'b0;
      trc_on       = 1'b0;
      rec_valid    = 1'b0;
      rec_code     = 2'b00;
      flush        = 1'b0;
      dct_ready    = 1'b0;
      clr_overflow = 1'b0;
      idle(2);
      chk("rst_valid", 32'(dct_valid), 32'd0);
      chk("rst_buffer", 32'(dct_buffer), 32'd0);
      chk("rst_count", 32'(dct_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      reset_n   = 1'b1;
      trc_on    = 1'b1;
      dct_ready = 1'b1;
      idle(2);

      // Uniform-code words: full words emit on their own, partial ones on flush.
      for (int v = 0; v < 6; v++) begin
         q.push_back('{vt[v].buffer, vt[v].count});
         for (int k = 0; k < vt[v].n; k++) rec(vt[v].code);
         if (vt[v].n < MAX_REC) do_flush();
         chk("lat_early_valid", 32'(dct_valid), 32'd0);
         @(posedge clk);
         #1;
         chk("lat_valid", 32'(dct_valid), 32'd1);
         chk("lat_buffer", 32'(dct_buffer), 32'(vt[v].buffer));
         chk("lat_count", 32'(dct_count), 32'(vt[v].count));
         wait_drain("vec");
      end

      // Mixed codes, oldest record in the upper bits.
      q.push_back('{30'h0000001E, 4'd3});
      rec(2'b01);
      rec(2'b11);
      rec(2'b10);
      do_flush();
      wait_drain("mixed");

      // Illegal code is ignored.
      q.push_back('{30'h00000003, 4'd1});
      rec(2'b00);
      rec(2'b11);
      do_flush();
      wait_drain("illegal");

      // Record and flush in the same cycle with an empty accumulator.
      q.push_back('{30'h00000003, 4'd1});
      flush = 1'b1;
      rec(2'b11);
      flush = 1'b0;
      wait_drain("rec_flush");

      // Flush with nothing buffered produces no word.
      do_flush();
      idle(5);

      // Back-pressure: first word held, second fills, further records dropped.
      dct_ready = 1'b0;
      for (int k = 0; k < 30; k++) rec(2'b11);
      chk("bp_valid", 32'(dct_valid), 32'd1);
      chk("bp_buffer", 32'(dct_buffer), 32'h3FFFFFFF);
      chk("bp_count", 32'(dct_count), 32'd15);
      chk("bp_ovf_before", 32'(overflow), 32'd0);
      rec(2'b11);
      chk("bp_ovf_drop", 32'(overflow), 32'(OVF));
      clr_overflow = 1'b1;
      rec(2'b11);
      chk("bp_ovf_clr_drop", 32'(overflow), 32'(OVF));
      @(posedge clk);
      #1;
      clr_overflow = 1'b0;
      chk("bp_ovf_clr", 32'(overflow), 32'd0);
      q.push_back('{30'h3FFFFFFF, 4'd15});
      q.push_back('{30'h3FFFFFFF, 4'd15});
      dct_ready = 1'b1;
      wait_drain("bp");

      // Trace stop closes the partial word; records while off are ignored.
      q.push_back('{30'h0000006D, 4'd4});
      rec(2'b01);
      rec(2'b10);
      rec(2'b11);
      rec(2'b01);
      trc_on = 1'b0;
      for (int k = 0; k < 5; k++) rec(2'b11);
      wait_drain("trc_stop");
      do_flush();
      idle(5);
      trc_on = 1'b1;
      idle(2);

      // Asynchronous reset drops a partial word.
      for (int k = 0; k < 7; k++) rec(2'b10);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(dct_valid), 32'd0);
      chk("arst_buffer", 32'(dct_buffer), 32'd0);
      chk("arst_count", 32'(dct_count), 32'd0);
      chk("arst_overflow", 32'(overflow), 32'd0);
      idle(2);
      reset_n = 1'b1;
      idle(3);
      do_flush();
      idle(10);
      chk("arst_no_word", 32'(dct_valid), 32'd0);

      // One more word after reset confirms the accumulator restarted empty.
      q.push_back('{30'h00000002, 4'd1});
      rec(2'b10);
      do_flush();
      wait_drain("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
